// File: rtl/otp_cipher_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared one-time-pad XOR
// cipher engine. One job is in flight at a time. Cipher jobs run the engine's
// level-sensitive start/done handshake, with a timeout. Bypass jobs use the
// engine's passthrough path. Every output is a register.
module otp_cipher_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RELEASE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_bypass,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_error,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_bypass,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_error,
    output logic [DATA_WIDTH-1:0] eng_input_data,
    output logic                  eng_start,
    output logic                  eng_passthrough,
    input  logic [DATA_WIDTH-1:0] eng_output_data,
    input  logic                  eng_done,
    output logic                  busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        RELEASE   = 3'd3,
        BYPASS    = 3'd4,
        RESPOND   = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         timer_reg, timer_next;
    logic [RW-1:0]         rel_cnt_reg, rel_cnt_next;
    logic                  settle_reg, settle_next;
    logic                  owner_reg, owner_next;
    logic                  last_grant_reg, last_grant_next;
    logic [DATA_WIDTH-1:0] job_data_reg, job_data_next;
    logic [DATA_WIDTH-1:0] result_reg, result_next;
    logic                  error_reg, error_next;

    // Next values for the registered outputs
    logic [1:0]            ready_next;
    logic [1:0]            rsp_valid_next;
    logic [1:0]            rsp_error_next;
    logic [DATA_WIDTH-1:0] rsp0_data_next, rsp1_data_next;
    logic [DATA_WIDTH-1:0] eng_input_data_next;
    logic                  eng_start_next;
    logic                  eng_passthrough_next;
    logic                  busy_next;

    logic [TW-1:0]         timer_inc;
    logic                  timeout_hit;
    logic                  grant0, grant1;
    logic [1:0]            rsp_hit;

    // Each requester gets its response only while its job is in RESPOND
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_hit
        assign rsp_hit[gi] = (state_reg == RESPOND) && (owner_reg == 1'(gi));
    end

    // Round-robin: when both requesters ask, the one not served last wins
    assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

    // The timer saturates. A timeout fires on the cycle the timer reaches the limit.
    assign timer_inc   = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + TW'(1);
    assign timeout_hit = (timer_inc == TIMER_MAX);

    // Next-state and next-output logic for the job sequencer
    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        rel_cnt_next    = rel_cnt_reg;
        settle_next     = settle_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        job_data_next   = job_data_reg;
        result_next     = result_reg;
        error_next      = error_reg;
        ready_next      = 2'b00;

        case (state_reg)
            IDLE: begin
                if (grant0 || grant1) begin
                    ready_next    = {grant1, grant0};
                    owner_next    = grant1;
                    job_data_next = grant1 ? req1_data : req0_data;
                    timer_next    = '0;
                    settle_next   = 1'b0;
                    error_next    = 1'b0;
                    result_next   = '0;
                    state_next    = (grant1 ? req1_bypass : req0_bypass) ? BYPASS : START;
                end
            end
            START: begin
                timer_next = timer_inc;
                // done low means the engine took the job, even if it was already low on entry
                if (!eng_done) begin
                    state_next = WAIT_DONE;
                end else if (timeout_hit) begin
                    result_next  = '0;
                    error_next   = 1'b1;
                    rel_cnt_next = '0;
                    state_next   = RELEASE;
                end
            end
            WAIT_DONE: begin
                timer_next = timer_inc;
                if (eng_done) begin
                    result_next  = eng_output_data;
                    rel_cnt_next = '0;
                    state_next   = RELEASE;
                end else if (timeout_hit) begin
                    result_next  = '0;
                    error_next   = 1'b1;
                    rel_cnt_next = '0;
                    state_next   = RELEASE;
                end
            end
            RELEASE: begin
                // start held low here so the engine drops its per-transaction lock
                if (rel_cnt_reg == REL_LAST) begin
                    rel_cnt_next = '0;
                    state_next   = RESPOND;
                end else begin
                    rel_cnt_next = rel_cnt_reg + RW'(1);
                end
            end
            BYPASS: begin
                if (!settle_reg) begin
                    settle_next = 1'b1;
                end else begin
                    result_next = eng_output_data;
                    error_next  = 1'b0;
                    state_next  = RESPOND;
                end
            end
            RESPOND: begin
                last_grant_next = owner_reg;
                timer_next      = '0;
                error_next      = 1'b0;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        rsp_valid_next       = rsp_hit;
        rsp_error_next       = rsp_hit & {2{error_reg}};
        rsp0_data_next       = rsp_hit[0] ? result_reg : '0;
        rsp1_data_next       = rsp_hit[1] ? result_reg : '0;
        eng_input_data_next  = (state_next == IDLE) ? '0 : job_data_next;
        eng_start_next       = (state_next == START) || (state_next == WAIT_DONE);
        eng_passthrough_next = (state_next == BYPASS);
        busy_next            = (state_next != IDLE);
    end

    // State, job context and output registers. Reset clears the engine controls at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            rel_cnt_reg     <= '0;
            settle_reg      <= 1'b0;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            job_data_reg    <= '0;
            result_reg      <= '0;
            error_reg       <= 1'b0;
            req0_ready      <= 1'b0;
            req1_ready      <= 1'b0;
            rsp0_valid      <= 1'b0;
            rsp1_valid      <= 1'b0;
            rsp0_error      <= 1'b0;
            rsp1_error      <= 1'b0;
            rsp0_data       <= '0;
            rsp1_data       <= '0;
            eng_input_data  <= '0;
            eng_start       <= 1'b0;
            eng_passthrough <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            rel_cnt_reg     <= rel_cnt_next;
            settle_reg      <= settle_next;
            owner_reg       <= owner_next;
            last_grant_reg  <= last_grant_next;
            job_data_reg    <= job_data_next;
            result_reg      <= result_next;
            error_reg       <= error_next;
            req0_ready      <= ready_next[0];
            req1_ready      <= ready_next[1];
            rsp0_valid      <= rsp_valid_next[0];
            rsp1_valid      <= rsp_valid_next[1];
            rsp0_error      <= rsp_error_next[0];
            rsp1_error      <= rsp_error_next[1];
            rsp0_data       <= rsp0_data_next;
            rsp1_data       <= rsp1_data_next;
            eng_input_data  <= eng_input_data_next;
            eng_start       <= eng_start_next;
            eng_passthrough <= eng_passthrough_next;
            busy            <= busy_next;
        end
    end

endmodule

// File: tb/tb_otp_cipher_arbiter.sv
// Testbench for otp_cipher_arbiter. It includes a behavioural OTP engine with
// key 16'h3327 and a simple arbitration and result model.
module tb_otp_cipher_arbiter;

    localparam int          DW      = 16;
    localparam int          TIMEOUT = 16;
    localparam logic [15:0] KEY     = 16'h3327;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_bypass = 1'b0, req1_bypass = 1'b0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic [DW-1:0] eng_input_data, eng_output_data;
    logic          eng_start, eng_passthrough, eng_done;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    int m_last = 1;     // model: requester served last (reset value 1)
    bit stuck = 1'b0;   // engine fault injection: done stuck high

    always #5 clk = ~clk;

    otp_cipher_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TIMEOUT), .RELEASE_CYCLES(1)) dut (
        .clk(clk), .reset(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_bypass(req0_bypass), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_error(rsp0_error),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_bypass(req1_bypass), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_error(rsp1_error),
        .eng_input_data(eng_input_data), .eng_start(eng_start), .eng_passthrough(eng_passthrough),
        .eng_output_data(eng_output_data), .eng_done(eng_done), .busy(busy)
    );

    // Engine model. done is high when idle. A start drops done (busy) for one
    // cycle, then done rises with data^KEY. The engine then stays locked until
    // start is seen low. Passthrough is combinational.
    logic [DW-1:0] e_out;
    logic          e_done, e_busy, e_lock;
    assign eng_output_data = eng_passthrough ? eng_input_data : e_out;
    assign eng_done        = stuck ? 1'b1 : e_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_out <= '0; e_done <= 1'b1; e_busy <= 1'b0; e_lock <= 1'b0;
        end else if (e_busy) begin
            e_out <= eng_input_data ^ KEY; e_done <= 1'b1; e_busy <= 1'b0; e_lock <= 1'b1;
        end else if (eng_start && !e_lock) begin
            e_done <= 1'b0; e_busy <= 1'b1;
        end else if (!eng_start) begin
            e_lock <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a ready pulse. port = -1 on timeout, 2 if both pulse.
    task automatic wait_grant(output int port, output int waited);
        port = -1; waited = 0;
        for (int i = 0; i < 40 && port < 0; i++) begin
            @(negedge clk); waited++;
            if (req0_ready && req1_ready) port = 2;
            else if (req0_ready)          port = 0;
            else if (req1_ready)          port = 1;
        end
    endtask

    // Called on the ready cycle. Follows the job to its response and checks it against the model.
    task automatic finish_job(input int p, input logic [15:0] d, input bit b, input bit tmo);
        logic [15:0] exp_data, obs_data;
        logic        obs_err;
        int exp_lat, lat, st_cnt, pt_cnt;
        bit got, stray;
        exp_data = tmo ? 16'h0000 : (b ? d : d ^ KEY);
        exp_lat  = b ? 3 : (tmo ? TIMEOUT + 2 : 5);
        check("eng_input_data", eng_input_data, d);
        check("busy_at_grant", busy, 1);
        st_cnt = eng_start; pt_cnt = eng_passthrough;
        lat = 0; got = 0; stray = 0; obs_data = '0; obs_err = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); lat++;
            if (req0_ready || req1_ready) stray = 1;
            if (p == 0 ? rsp1_valid : rsp0_valid) stray = 1;
            if (p == 0 ? rsp0_valid : rsp1_valid) begin
                got = 1;
                obs_data = (p == 0) ? rsp0_data : rsp1_data;
                obs_err  = (p == 0) ? rsp0_error : rsp1_error;
            end else begin
                st_cnt += int'(eng_start);
                pt_cnt += int'(eng_passthrough);
            end
        end
        check("rsp_seen", got, 1);
        check("rsp_latency", lat, exp_lat);
        check("rsp_data", obs_data, exp_data);
        check("rsp_error", obs_err, tmo);
        check("no_stray_ready_or_rsp", stray, 0);
        check("eng_start_cycles", st_cnt, b ? 0 : (tmo ? TIMEOUT : 3));
        if (b) check("bypass_pt_cycles_in_range", (pt_cnt >= 1 && pt_cnt <= 2), 1);
        else   check("cipher_pt_cycles", pt_cnt, 0);
    endtask

    // Present up to two jobs at once. The model predicts the service order.
    task automatic run_round(input bit v0, input bit v1, input logic [15:0] d0, input logic [15:0] d1,
                             input bit b0, input bit b1, input bit tmo);
        int order[$];
        int port, waited;
        req0_valid = v0; req0_data = d0; req0_bypass = b0;
        req1_valid = v1; req1_data = d1; req1_bypass = b1;
        if (v0 && v1) order = (m_last == 0) ? '{1, 0} : '{0, 1};
        else if (v0)  order = '{0};
        else          order = '{1};
        foreach (order[k]) begin
            wait_grant(port, waited);
            $display("grant: expected port %0d, observed %0d after %0d cycles", order[k], port, waited);
            check("grant_port", port, order[k]);
            if (k > 0) check("regrant_gap", waited, 1);
            if (port != order[k]) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                return;
            end
            if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
            finish_job(port, port ? d1 : d0, port ? b1 : b0, tmo);
            m_last = port;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int port, waited, rsp_cnt;
        logic [15:0] ra, rb;
        int pat;

        // Reset state
        #3;
        check("reset_busy", busy, 0);
        check("reset_eng_start", eng_start, 0);
        check("reset_eng_pt", eng_passthrough, 0);
        check("reset_ready", {req0_ready, req1_ready}, 0);
        check("reset_rsp", {rsp0_valid, rsp1_valid, rsp0_error, rsp1_error}, 0);
        check("reset_data", {rsp0_data, rsp1_data, eng_input_data}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single cipher job, then a simultaneous pair, then another pair
        run_round(1, 0, 16'h1234, 16'h0000, 0, 0, 0);
        run_round(1, 1, 16'hAAAA, 16'h5555, 0, 0, 0);
        run_round(1, 1, 16'($urandom), 16'($urandom), 0, 0, 0);

        // Bypass job on requester 1
        run_round(0, 1, 16'h0000, 16'hBEEF, 0, 1, 0);

        // Engine done stuck high -> timeout, then a normal job
        stuck = 1'b1;
        run_round(1, 0, 16'h1357, 16'h0000, 0, 0, 1);
        stuck = 1'b0;
        @(negedge clk);
        run_round(1, 0, 16'h2468, 16'h0000, 0, 0, 0);

        // Back-to-back requester 0 jobs with valid held across them
        req0_valid = 1'b1; req0_data = 16'h0000; req0_bypass = 1'b0;
        wait_grant(port, waited);
        check("b2b_first_port", port, 0);
        req0_data = 16'hFFFF;
        finish_job(0, 16'h0000, 0, 0);
        wait_grant(port, waited);
        check("b2b_second_port", port, 0);
        check("b2b_gap", waited, 1);
        req0_valid = 1'b0;
        finish_job(0, 16'hFFFF, 0, 0);
        m_last = 0;

        // Reset during WAIT_DONE
        req0_valid = 1'b1; req0_data = 16'h0F0F;
        wait_grant(port, waited);
        check("rst_mid_port", port, 0);
        req0_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        check("rst_mid_start_before", eng_start, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_start", eng_start, 0);
        check("rst_mid_pt", eng_passthrough, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        rsp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rsp_cnt += int'(rsp0_valid) + int'(rsp1_valid);
        end
        check("rst_mid_no_rsp", rsp_cnt, 0);
        m_last = 1;
        run_round(1, 1, 16'h3C3C, 16'hC0DE, 0, 0, 0);
        run_round(0, 1, 16'h0000, 16'h7777, 0, 0, 0);

        // Randomized rounds against the model
        for (int r = 0; r < 20; r++) begin
            pat = int'($urandom_range(1, 3));
            ra = 16'($urandom); rb = 16'($urandom);
            run_round(pat[0], pat[1], ra, rb, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
